// File: rtl/bus_pkg.sv
// Shared definitions for bus initiators on the 32-bit memory bus.
// Address/data widths, copy-master states, default timeout.
package bus_pkg;

  localparam int BUS_AW      = 32;
  localparam int BUS_DW      = 32;
  localparam int WORD_BYTES  = 4;
  localparam int TIMEOUT_DEF = 256;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    FIN
  } cm_state_e;

endpackage

// File: rtl/bus_txn_timer.sv
// Per-transaction wait timer for bus initiators.
// Counts enabled cycles since clear; flags the last allowed cycle.
import bus_pkg::*;

module bus_txn_timer #(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  assign o_expired = i_en && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bus_copy_master.sv
// Word-by-word block copier driving the requester side of the bus.
// Alternates a held read and a write per word; aborts on timeout.
import bus_pkg::*;

module bus_copy_master #(
  parameter int LEN_W          = 12,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [BUS_AW-1:0] src_addr,
  input  logic [BUS_AW-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [BUS_AW-1:0] bus_addr,
  output logic [BUS_DW-1:0] bus_wdata,
  output logic              bus_rd,
  output logic              bus_wr,
  input  logic [BUS_DW-1:0] bus_rdata,
  input  logic              bus_ready
);

  localparam logic [BUS_AW-1:0] STEP  = BUS_AW'(WORD_BYTES);
  localparam logic [BUS_AW-1:0] AMASK = ~BUS_AW'(WORD_BYTES - 1);

  cm_state_e         r_state;
  cm_state_e         w_next;
  logic [BUS_AW-1:0] r_src;
  logic [BUS_AW-1:0] r_dst;
  logic [BUS_DW-1:0] r_data;
  logic [LEN_W-1:0]  r_rem;
  logic              r_err;
  logic              r_held;

  logic w_rd_acc;
  logic w_wr_acc;
  logic w_exp;
  logic w_tmo;
  logic w_in_txn;

  assign w_in_txn = (r_state == READ) || (r_state == WRITE);
  // Read data is only trusted once the address has been held a full cycle.
  assign w_rd_acc = (r_state == READ) && bus_ready && r_held;
  assign w_wr_acc = (r_state == WRITE) && bus_ready;
  assign w_tmo    = w_exp && !w_rd_acc && !w_wr_acc;

  bus_txn_timer #(
    .TIMEOUT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (w_next != r_state),
    .i_en      (w_in_txn),
    .o_expired (w_exp)
  );

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_next = (len == '0) ? FIN : READ;
      end
      READ: begin
        if (w_rd_acc)   w_next = WRITE;
        else if (w_tmo) w_next = FIN;
      end
      WRITE: begin
        if (w_wr_acc)   w_next = (r_rem == LEN_W'(1)) ? FIN : READ;
        else if (w_tmo) w_next = FIN;
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_data  <= '0;
      r_rem   <= '0;
      r_err   <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_held  <= (r_state == READ) && (w_next == READ);
      if (r_state == IDLE && start) begin
        r_src <= src_addr & AMASK;
        r_dst <= dst_addr & AMASK;
        r_rem <= len;
        r_err <= 1'b0;
      end
      if (w_rd_acc) r_data <= bus_rdata;
      if (w_wr_acc) begin
        r_src <= r_src + STEP;
        r_dst <= r_dst + STEP;
        r_rem <= r_rem - LEN_W'(1);
      end
      if (w_in_txn && w_tmo) r_err <= 1'b1;
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FIN);
  assign err       = (r_state == FIN) && r_err;
  assign bus_rd    = (r_state == READ);
  assign bus_wr    = (r_state == WRITE);
  assign bus_addr  = (r_state == READ)  ? r_src :
                     (r_state == WRITE) ? r_dst : '0;
  assign bus_wdata = (r_state == WRITE) ? r_data : '0;

endmodule

// File: tb/tb_bus_copy_master.sv
// Bench for bus_copy_master: RAM responder with stale-address read data,
// random wait states, and a word-list copy reference model.
module tb_bus_copy_master;

  localparam int MW = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0;
  logic [31:0] dst_addr = '0;
  logic [11:0] len = '0;
  logic        busy, done, err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_rd, bus_wr, bus_ready;

  logic [31:0] mem  [0:MW-1];
  logic [31:0] refm [0:MW-1];
  logic [31:0] r_prev = '0;
  logic        rdy_rand = 1'b1;
  bit          rand_wait = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int rd_cyc = 0, wr_cyc = 0, done_cnt = 0, viol = 0;

  bus_copy_master dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .src_addr  (src_addr),
    .dst_addr  (dst_addr),
    .len       (len),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready)
  );

  always #5 clk = ~clk;

  function automatic bit dec(input logic [31:0] a);
    return a < 32'h0001_0000;
  endfunction

  // Responder: data follows the previous cycle's address.
  always_comb begin
    bus_rdata = '0;
    if (dec(r_prev)) bus_rdata = mem[r_prev[15:2]];
  end
  assign bus_ready = dec(bus_addr) && (bus_rd || bus_wr) && rdy_rand;

  always @(posedge clk) begin
    r_prev <= bus_addr;
    if (bus_wr && bus_ready) mem[bus_addr[15:2]] = bus_wdata;
  end

  always @(negedge clk) begin
    rdy_rand <= rand_wait ? ($urandom_range(0, 2) != 0) : 1'b1;
    if (bus_rd) rd_cyc++;
    if (bus_wr) wr_cyc++;
    if (done) done_cnt++;
    if (bus_rd && bus_wr) viol++;
    if ((done || !busy) && (bus_rd || bus_wr)) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_copy(input logic [31:0] s0, input logic [31:0] d0,
                          input int n, output bit e);
    logic [31:0] s, d;
    s = s0 & ~32'h3;
    d = d0 & ~32'h3;
    e = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!dec(s) || !dec(d)) begin
        e = 1'b1;
        break;
      end
      refm[d[15:2]] = refm[s[15:2]];
      s = s + 32'd4;
      d = d + 32'd4;
    end
  endtask

  task automatic cmp_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < MW; i++) if (mem[i] !== refm[i]) bad++;
    chk(tag, 64'(bad), 64'd0);
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d,
                          input int n, input bit poke,
                          output int bcyc, output bit e);
    bit seen = 1'b0;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = 12'(n);
    @(negedge clk);
    start = 1'b0;
    bcyc = 0;
    e = 1'b0;
    for (int k = 0; k < 5000; k++) begin
      if (busy) bcyc++;
      if (done) begin
        seen = 1'b1;
        e = err;
        break;
      end
      start = poke && (k == 4 || k == 7);
      if (start) begin
        src_addr = 32'h300; dst_addr = 32'h400; len = 12'd3;
      end
      @(negedge clk);
      start = 1'b0;
    end
    chk("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    chk("done_pulse", {62'd0, done, busy}, 64'd0);
  endtask

  initial begin
    int  bc, r0, w0, d0;
    bit  e, ee;
    logic [31:0] s, d;
    int  n;

    for (int i = 0; i < MW; i++) begin
      mem[i]  = $urandom;
      refm[i] = mem[i];
    end

    #3;
    chk("reset_outs", {busy, done, err, bus_rd, bus_wr, bus_addr, bus_wdata},
        '0);
    #4 rst_n = 1'b1;
    r0 = rd_cyc; w0 = wr_cyc;
    repeat (20) @(negedge clk);
    chk("idle_quiet", 64'((rd_cyc - r0) + (wr_cyc - w0)), 64'd0);

    // Basic zero-wait copy
    run_copy(32'h100, 32'h200, 4, 1'b0, bc, e);
    ref_copy(32'h100, 32'h200, 4, ee);
    chk("basic_busy", 64'(bc), 64'd13);
    chk("basic_err", 64'(e), 64'(ee));
    cmp_mem("basic_mem");

    // len = 0
    r0 = rd_cyc; w0 = wr_cyc;
    run_copy(32'h100, 32'h200, 0, 1'b0, bc, e);
    chk("len0_busy", 64'(bc), 64'd1);
    chk("len0_bus", 64'((rd_cyc - r0) + (wr_cyc - w0)), 64'd0);
    chk("len0_err", 64'(e), 64'd0);

    // Overlapping regions, unaligned low bits ignored
    run_copy(32'h102, 32'h107, 2, 1'b0, bc, e);
    ref_copy(32'h100, 32'h104, 2, ee);
    chk("ovl_busy", 64'(bc), 64'd7);
    chk("ovl_val", 64'(mem[32'h108 >> 2]), 64'(mem[32'h100 >> 2]));
    cmp_mem("ovl_mem");

    // Undecoded destination: write times out
    w0 = wr_cyc;
    run_copy(32'h40, 32'h0001_0000, 1, 1'b0, bc, e);
    ref_copy(32'h40, 32'h0001_0000, 1, ee);
    chk("wto_err", 64'(e), 64'(ee));
    chk("wto_busy", 64'(bc), 64'd259);
    chk("wto_wrcyc", 64'(wr_cyc - w0), 64'd256);
    cmp_mem("wto_mem");

    // Undecoded source: read times out
    r0 = rd_cyc;
    run_copy(32'h0002_0000, 32'h500, 3, 1'b0, bc, e);
    ref_copy(32'h0002_0000, 32'h500, 3, ee);
    chk("rto_err", 64'(e), 64'(ee));
    chk("rto_busy", 64'(bc), 64'd257);
    chk("rto_rdcyc", 64'(rd_cyc - r0), 64'd256);
    cmp_mem("rto_mem");

    // start pulsed while busy must be ignored
    run_copy(32'h600, 32'h700, 5, 1'b1, bc, e);
    ref_copy(32'h600, 32'h700, 5, ee);
    chk("poke_busy", 64'(bc), 64'd16);
    cmp_mem("poke_mem");

    // Randomized copies with random wait states
    rand_wait = 1'b1;
    for (int t = 0; t < 8; t++) begin
      s = 32'($urandom_range(0, 4000)) * 32'd4;
      d = 32'($urandom_range(0, 4000)) * 32'd4;
      n = $urandom_range(1, 16);
      run_copy(s, d, n, 1'b0, bc, e);
      ref_copy(s, d, n, ee);
      chk("rnd_err", 64'(e), 64'(ee));
      cmp_mem("rnd_mem");
    end
    rand_wait = 1'b0;

    // Reset asserted while a write is on the bus
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; src_addr = 32'h800; dst_addr = 32'h900; len = 12'd3;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 50 && !bus_wr; k++) @(negedge clk);
    chk("rst_wr_seen", 64'(bus_wr), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {61'd0, bus_wr, bus_rd, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_nodone", 64'(done_cnt - d0), 64'd0);
    cmp_mem("rst_mem");
    run_copy(32'h800, 32'h900, 3, 1'b0, bc, e);
    ref_copy(32'h800, 32'h900, 3, ee);
    chk("post_rst_busy", 64'(bc), 64'd10);
    cmp_mem("post_rst_mem");

    chk("protocol", 64'(viol), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
